// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: memory map, funct3 load/store encodings,
// load/store unit state type and bus byte-lane helpers.
package RISCV_PKG;

  localparam int unsigned MEM_BYTES = 65536;
  localparam int unsigned HALF_MEM  = MEM_BYTES / 2;
  localparam int          BUS_BE_W  = 4;

  // Load encodings; stores reuse the same width codes.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_t;

  localparam funct3_t SB = LB;
  localparam funct3_t SH = LH;
  localparam funct3_t SW = LW;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} lsu_state_t;

  // Byte lanes of an access before shifting by the address offset.
  function automatic logic [BUS_BE_W-1:0] base_mask(input logic [1:0] f3lo);
    case (f3lo)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Access size in bytes.
  function automatic logic [2:0] access_size(input logic [1:0] f3lo);
    case (f3lo)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data alignment: joins up to two bus words, shifts the addressed
// byte into lane 0 and sign/zero-extends to 32 bits.
module lsu_load_align
  import RISCV_PKG::*;
(
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] r32;

  // Shift the two-word window down by the byte offset, then extend by width
  always_comb begin
    r32 = 32'({hi_word, lo_word} >> {off, 3'b000});
    case (funct3)
      LB:      data = {{24{r32[7]}}, r32[7:0]};
      LH:      data = {{16{r32[15]}}, r32[15:0]};
      LBU:     data = {24'b0, r32[7:0]};
      LHU:     data = {16'b0, r32[15:0]};
      default: data = r32;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator for the RV32I datapath. Turns one load/store into
// one or two word-aligned byte-enabled bus beats, stalls the datapath while
// busy, and returns extended load data or a fault pulse.
module load_store_unit
  import RISCV_PKG::*;
#(
  parameter int unsigned DATA_LIMIT  = HALF_MEM,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] DataAddress,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessFault,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusByteEn,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  lsu_state_t state, state_nxt;

  // Request decode, only meaningful in IDLE
  logic [1:0]  off;
  logic [7:0]  mask8;
  logic [63:0] w64;
  logic [32:0] last_byte;
  logic        req_fault;

  assign off       = DataAddress[1:0];
  assign mask8     = {4'b0, base_mask(Funct3[1:0])} << off;
  assign w64       = {32'b0, WriteData} << {off, 3'b000};
  // 33-bit sum so addresses near the top of the space cannot wrap into range
  assign last_byte = {1'b0, DataAddress} + 33'(access_size(Funct3[1:0])) - 33'd1;
  assign req_fault = (MemRead && MemWrite)
                  || (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11)
                  || (MemWrite && Funct3[2])
                  || (last_byte >= 33'(DATA_LIMIT));

  // Latched request
  logic        we_q, need2_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be1_q;
  logic [31:0] wd1_q, rd0_q, cnt;

  logic ack, tmo;
  assign ack = BusReq && BusAck;
  assign tmo = (ACK_TIMEOUT != 0) && (cnt == 32'(ACK_TIMEOUT - 1));

  assign Stall = (MemRead || MemWrite) && (state != DONE);

  logic [31:0] align_lo, align_hi, align_data;
  assign align_lo = (state == BEAT1) ? rd0_q : BusRData;
  assign align_hi = (state == BEAT1) ? BusRData : 32'b0;

  lsu_load_align u_align (
    .lo_word (align_lo),
    .hi_word (align_hi),
    .off     (off_q),
    .funct3  (f3_q),
    .data    (align_data)
  );

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; an ack in the expiry cycle wins over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MemRead || MemWrite) state_nxt = req_fault ? DONE : BEAT0;
      BEAT0:   if (ack)      state_nxt = need2_q ? BEAT1 : DONE;
               else if (tmo) state_nxt = DONE;
      BEAT1:   if (ack || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs, latched request, timeout counter and result registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      we_q <= 1'b0; need2_q <= 1'b0; f3_q <= '0; off_q <= '0;
      be1_q <= '0; wd1_q <= '0; rd0_q <= '0; cnt <= '0;
      BusReq <= 1'b0; BusWe <= 1'b0; BusAddr <= '0; BusByteEn <= '0; BusWData <= '0;
      ReadData <= '0; AccessFault <= 1'b0;
    end else begin
      AccessFault <= 1'b0;
      ReadData    <= '0;
      case (state)
        IDLE: if (MemRead || MemWrite) begin
          we_q    <= MemWrite;
          f3_q    <= Funct3;
          off_q   <= off;
          need2_q <= |mask8[7:4];
          be1_q   <= mask8[7:4];
          wd1_q   <= w64[63:32];
          cnt     <= '0;
          if (req_fault) AccessFault <= 1'b1;
          else begin
            BusReq    <= 1'b1;
            BusWe     <= MemWrite;
            BusAddr   <= {DataAddress[31:2], 2'b00};
            BusByteEn <= mask8[3:0];
            BusWData  <= w64[31:0];
          end
        end
        BEAT0, BEAT1: begin
          if (ack) begin
            cnt <= '0;
            if (state == BEAT0 && need2_q) begin
              // Keep BusReq high and move straight to the next word
              rd0_q     <= BusRData;
              BusAddr   <= BusAddr + 32'd4;
              BusByteEn <= be1_q;
              BusWData  <= wd1_q;
            end else begin
              BusReq <= 1'b0; BusWe <= 1'b0; BusAddr <= '0; BusByteEn <= '0; BusWData <= '0;
              if (!we_q) ReadData <= align_data;
            end
          end else if (tmo) begin
            // An already-acked first store beat is left in memory
            BusReq <= 1'b0; BusWe <= 1'b0; BusAddr <= '0; BusByteEn <= '0; BusWData <= '0;
            AccessFault <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small scripted memory responder.
module tb_load_store_unit;

  localparam int unsigned LIMIT = 32'h0000_8000;

  logic        CLK = 1'b0, Reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  Funct3 = '0;
  logic [31:0] DataAddress = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall, AccessFault, BusReq, BusWe;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusByteEn;
  logic        BusAck = 1'b0;
  logic [31:0] BusRData = '0;

  int errors = 0, checks = 0;

  load_store_unit #(.DATA_LIMIT(LIMIT), .ACK_TIMEOUT(16)) dut (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .DataAddress(DataAddress), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AccessFault(AccessFault),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusByteEn(BusByteEn),
    .BusWData(BusWData), .BusAck(BusAck), .BusRData(BusRData)
  );

  always #5 CLK = ~CLK;

  // Scripted memory: per-beat wait cycles and read data, logs what it accepted
  bit          resp_on = 1'b0;
  int          wait_cfg [2];
  logic [31:0] rd_cfg [2];
  int          bidx = 0, wcnt = 0, req_cycles = 0;
  logic [31:0] log_addr [2];
  logic [31:0] log_wd [2];
  logic [3:0]  log_be [2];
  logic        log_we [2];

  initial begin
    forever begin
      @(negedge CLK);
      if (BusReq) req_cycles++;
      if (resp_on && BusReq && Reset && bidx < 2) begin
        if (wcnt >= wait_cfg[bidx]) begin
          BusAck = 1'b1; BusRData = rd_cfg[bidx];
          log_addr[bidx] = BusAddr; log_be[bidx] = BusByteEn;
          log_wd[bidx] = BusWData; log_we[bidx] = BusWe;
          bidx++; wcnt = 0;
        end else begin
          BusAck = 1'b0; BusRData = '0; wcnt++;
        end
      end else begin
        BusAck = 1'b0; BusRData = '0;
      end
    end
  end

  // Issue one request (called just after a posedge) and wait for Stall to drop
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int ncyc, output logic [31:0] rdata, output logic flt);
    bidx = 0; wcnt = 0; req_cycles = 0;
    MemRead = rd; MemWrite = wr; Funct3 = f3; DataAddress = a; WriteData = wd;
    ncyc = -1; rdata = 'x; flt = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      if (!Stall) begin
        ncyc = i; rdata = ReadData; flt = AccessFault;
        break;
      end
    end
    @(posedge CLK); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BusReq, BusWe, BusAddr, BusByteEn, BusWData, ReadData, AccessFault, Stall} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got req=%b we=%b addr=%h be=%b wd=%h rd=%h flt=%b stall=%b want all zero",
               BusReq, BusWe, BusAddr, BusByteEn, BusWData, ReadData, AccessFault, Stall);
    end
    Reset = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_aligned_lw;
    int n; logic [31:0] rd; logic fl;
    resp_on = 1'b1; wait_cfg = '{0, 0}; rd_cfg = '{32'hDEADBEEF, 32'h0};
    do_access(1, 0, 3'b010, 32'h10, 32'h0, n, rd, fl);
    checks++; if (n !== 3) begin errors++; $display("FAIL lw cycles: got %0d want 3", n); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw data: got %h want deadbeef", rd); end
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL lw fault: got %b want 0", fl); end
    checks++; if (bidx !== 1) begin errors++; $display("FAIL lw beats: got %0d want 1", bidx); end
    checks++;
    if (log_addr[0] !== 32'h10 || log_be[0] !== 4'b1111 || log_we[0] !== 1'b0) begin
      errors++; $display("FAIL lw beat0: got addr=%h be=%b we=%b want 00000010 1111 0", log_addr[0], log_be[0], log_we[0]);
    end
  endtask

  task automatic test_byte_loads;
    int n; logic [31:0] rd; logic fl;
    resp_on = 1'b1; wait_cfg = '{0, 0}; rd_cfg = '{32'h80FF0000, 32'h0};
    do_access(1, 0, 3'b000, 32'h13, 32'h0, n, rd, fl);
    checks++; if (n !== 3) begin errors++; $display("FAIL lb cycles: got %0d want 3", n); end
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb data: got %h want ffffff80", rd); end
    checks++;
    if (log_addr[0] !== 32'h10 || log_be[0] !== 4'b1000) begin
      errors++; $display("FAIL lb beat0: got addr=%h be=%b want 00000010 1000", log_addr[0], log_be[0]);
    end
    do_access(1, 0, 3'b100, 32'h13, 32'h0, n, rd, fl);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu data: got %h want 00000080", rd); end
  endtask

  task automatic test_split_store;
    int n; logic [31:0] rd; logic fl;
    resp_on = 1'b1; wait_cfg = '{0, 0}; rd_cfg = '{32'h0, 32'h0};
    do_access(0, 1, 3'b010, 32'h06, 32'h11223344, n, rd, fl);
    checks++; if (n !== 4) begin errors++; $display("FAIL sw split cycles: got %0d want 4", n); end
    checks++; if (bidx !== 2) begin errors++; $display("FAIL sw split beats: got %0d want 2", bidx); end
    checks++;
    if (log_addr[0] !== 32'h04 || log_be[0] !== 4'b1100 || log_wd[0] !== 32'h33440000 || log_we[0] !== 1'b1) begin
      errors++; $display("FAIL sw beat0: got addr=%h be=%b wd=%h we=%b want 00000004 1100 33440000 1",
                         log_addr[0], log_be[0], log_wd[0], log_we[0]);
    end
    checks++;
    if (log_addr[1] !== 32'h08 || log_be[1] !== 4'b0011 || log_wd[1] !== 32'h00001122 || log_we[1] !== 1'b1) begin
      errors++; $display("FAIL sw beat1: got addr=%h be=%b wd=%h we=%b want 00000008 0011 00001122 1",
                         log_addr[1], log_be[1], log_wd[1], log_we[1]);
    end
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL sw split fault: got %b want 0", fl); end
  endtask

  task automatic test_split_load_wait;
    int n; logic [31:0] rd; logic fl;
    resp_on = 1'b1; wait_cfg = '{0, 0}; rd_cfg = '{32'h7F000000, 32'h000000A5};
    do_access(1, 0, 3'b001, 32'h0B, 32'h0, n, rd, fl);
    checks++; if (n !== 4) begin errors++; $display("FAIL lh split cycles: got %0d want 4", n); end
    checks++; if (rd !== 32'hFFFFA57F) begin errors++; $display("FAIL lh split data: got %h want ffffa57f", rd); end
    wait_cfg = '{0, 3};
    do_access(1, 0, 3'b001, 32'h0B, 32'h0, n, rd, fl);
    checks++; if (n !== 7) begin errors++; $display("FAIL lh wait cycles: got %0d want 7", n); end
    checks++; if (rd !== 32'hFFFFA57F) begin errors++; $display("FAIL lh wait data: got %h want ffffa57f", rd); end
    checks++;
    if (log_addr[0] !== 32'h08 || log_be[0] !== 4'b1000 || log_addr[1] !== 32'h0C || log_be[1] !== 4'b0001) begin
      errors++; $display("FAIL lh beats: got %h/%b %h/%b want 00000008/1000 0000000c/0001",
                         log_addr[0], log_be[0], log_addr[1], log_be[1]);
    end
  endtask

  task automatic test_faults;
    logic        rdv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        wrv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3v [5] = '{3'b100, 3'b010, 3'b010, 3'b010, 3'b011};
    logic [31:0] av  [5] = '{32'h20, LIMIT - 2, 32'h20, 32'hFFFFFFFE, 32'h0};
    int n; logic [31:0] rd; logic fl;
    resp_on = 1'b1; wait_cfg = '{0, 0}; rd_cfg = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      do_access(rdv[i], wrv[i], f3v[i], av[i], 32'hA5A5A5A5, n, rd, fl);
      checks++;
      if (n !== 2 || fl !== 1'b1 || rd !== 32'h0 || req_cycles !== 0) begin
        errors++; $display("FAIL fault[%0d]: got cycles=%0d flt=%b rd=%h reqcyc=%0d want 2 1 00000000 0",
                           i, n, fl, rd, req_cycles);
      end
    end
  endtask

  task automatic test_boundary;
    int n; logic [31:0] rd; logic fl;
    resp_on = 1'b1; wait_cfg = '{0, 0}; rd_cfg = '{32'hCAFEF00D, 32'h0};
    do_access(1, 0, 3'b010, LIMIT - 4, 32'h0, n, rd, fl);
    checks++;
    if (n !== 3 || fl !== 1'b0 || rd !== 32'hCAFEF00D || log_addr[0] !== LIMIT - 4) begin
      errors++; $display("FAIL lw top word: got cycles=%0d flt=%b rd=%h addr=%h want 3 0 cafef00d %h",
                         n, fl, rd, log_addr[0], LIMIT - 4);
    end
    do_access(1, 0, 3'b100, LIMIT - 1, 32'h0, n, rd, fl);
    checks++;
    if (n !== 3 || fl !== 1'b0 || rd !== 32'h000000CA || log_be[0] !== 4'b1000) begin
      errors++; $display("FAIL lbu top byte: got cycles=%0d flt=%b rd=%h be=%b want 3 0 000000ca 1000",
                         n, fl, rd, log_be[0]);
    end
  endtask

  task automatic test_timeout_reset;
    int n; logic [31:0] rd; logic fl;
    resp_on = 1'b0;
    do_access(1, 0, 3'b010, 32'h40, 32'h0, n, rd, fl);
    checks++;
    if (n !== 18 || fl !== 1'b1 || rd !== 32'h0 || req_cycles !== 16) begin
      errors++; $display("FAIL timeout: got cycles=%0d flt=%b rd=%h reqcyc=%0d want 18 1 00000000 16",
                         n, fl, rd, req_cycles);
    end
    // Reset while BEAT0 is waiting for an ack
    MemRead = 1'b1; Funct3 = 3'b010; DataAddress = 32'h40;
    @(negedge CLK); @(negedge CLK);
    checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL beat0 before reset: got req=%b want 1", BusReq); end
    @(negedge CLK);
    Reset = 1'b0; #1;
    checks++;
    if (BusReq !== 1'b0 || BusAddr !== 32'h0 || BusByteEn !== 4'b0) begin
      errors++; $display("FAIL async reset bus: got req=%b addr=%h be=%b want 0 00000000 0000", BusReq, BusAddr, BusByteEn);
    end
    @(posedge CLK); #1; MemRead = 1'b0;
    @(negedge CLK); Reset = 1'b1; req_cycles = 0;
    repeat (3) @(negedge CLK);
    checks++; if (req_cycles !== 0) begin errors++; $display("FAIL no beat after reset: got reqcyc=%0d want 0", req_cycles); end
    @(posedge CLK); #1;
    resp_on = 1'b1; wait_cfg = '{0, 0}; rd_cfg = '{32'h12345678, 32'h0};
    do_access(1, 0, 3'b010, 32'h44, 32'h0, n, rd, fl);
    checks++;
    if (n !== 3 || fl !== 1'b0 || rd !== 32'h12345678 || log_addr[0] !== 32'h44) begin
      errors++; $display("FAIL lw after reset: got cycles=%0d flt=%b rd=%h addr=%h want 3 0 12345678 00000044",
                         n, fl, rd, log_addr[0]);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_byte_loads();
    test_split_store();
    test_split_load_wait();
    test_faults();
    test_boundary();
    test_timeout_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
